// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: loaded with the round-10 key, it presents round keys
// 10 down to 0, one per accepted handshake, regenerating Rcon in reverse as it goes.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] acc;
      logic [7:0] t;
      acc = 8'h00;
      t   = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) acc = acc ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   logic [7:0] x2, x4, x8, x16, x32, x64, x128;
   logic [7:0] inv;

   // Multiplicative inverse as a^254; zero maps to zero on its own.
   always_comb begin
      x2   = gf_mul(a, a);
      x4   = gf_mul(x2, x2);
      x8   = gf_mul(x4, x4);
      x16  = gf_mul(x8, x8);
      x32  = gf_mul(x16, x16);
      x64  = gf_mul(x32, x32);
      x128 = gf_mul(x64, x64);
      inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                    gf_mul(gf_mul(x32, x64), x128));
   end

   assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_key_sched (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         key_ready,
   output logic         key_valid,
   output logic [127:0] round_key,
   output logic [3:0]   round_num,
   output logic         busy,
   output logic         done
);
   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t       state_reg;
   logic [7:0]   rcon_reg;
   logic [7:0]   rcon_next;
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  p3_rot;
   logic [31:0]  sub_word;
   logic [127:0] prev_key;

   assign w0 = round_key[127:96];
   assign w1 = round_key[95:64];
   assign w2 = round_key[63:32];
   assign w3 = round_key[31:0];
   assign p3_rot = {(w3[23:0] ^ w2[23:0]), (w3[31:24] ^ w2[31:24])};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         aes_sbox u_sbox (
            .a(p3_rot[gi*8 +: 8]),
            .s(sub_word[gi*8 +: 8])
         );
      end
   endgenerate

   assign prev_key = {w0 ^ sub_word ^ {rcon_reg, 24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2};

   // Division by x in GF(2^8): undo the reduction when the LSB shows it happened.
   assign rcon_next = rcon_reg[0] ? (((rcon_reg ^ 8'h1b) >> 1) | 8'h80) : (rcon_reg >> 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         key_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         round_key <= 128'h0;
         round_num <= 4'h0;
         rcon_reg  <= 8'h00;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg <= ACTIVE;
                  key_valid <= 1'b1;
                  busy      <= 1'b1;
                  round_key <= key_in;
                  round_num <= 4'ha;
                  rcon_reg  <= 8'h36;
               end
            end
            ACTIVE: begin
               if (key_ready) begin
                  if (round_num == 4'h0) begin
                     state_reg <= IDLE;
                     key_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     round_key <= prev_key;
                     round_num <= round_num - 4'h1;
                     rcon_reg  <= rcon_next;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched: expected round keys are queued at load
// time and popped on every handshake observed at the falling edge.

module tb_aes_inv_key_sched;
   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         key_ready;
   logic         key_valid;
   logic [127:0] round_key;
   logic [3:0]   round_num;
   logic         busy;
   logic         done;

   typedef struct packed {
      logic [3:0]   rn;
      logic [127:0] key;
      logic         chk;
   } exp_t;

   exp_t         sb[$];
   logic [127:0] a1_keys [0:10];
   logic [7:0]   rcon_exp [0:10];
   int           asserts;
   int           fails;

   aes_inv_key_sched dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .key_in(key_in),
      .key_ready(key_ready),
      .key_valid(key_valid),
      .round_key(round_key),
      .round_num(round_num),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic push_a1();
      for (int r = 10; r >= 0; r--) sb.push_back('{rn: 4'(r), key: a1_keys[r], chk: 1'b1});
   endtask

   task automatic push_zero();
      sb.push_back('{rn: 4'ha, key: 128'hb4ef5bcb3e92e21123e951cf6f8f188e, chk: 1'b1});
      for (int r = 9; r >= 1; r--) sb.push_back('{rn: 4'(r), key: 128'h0, chk: 1'b0});
      sb.push_back('{rn: 4'h0, key: 128'h0, chk: 1'b1});
   endtask

   // Called just after a falling edge; returns at the falling edge where round 10 is shown.
   task automatic do_start(input logic [127:0] k);
      start  = 1'b1;
      key_in = k;
      @(negedge clk);
      start  = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      key_in = '1;
      repeat (3) @(negedge clk);
      asserts++;
      if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_flags: valid=%b busy=%b done=%b expected 000", key_valid, busy, done);
      end
      asserts++;
      if (round_key !== 128'h0 || round_num !== 4'h0 || dut.rcon_reg !== 8'h00) begin
         fails++;
         $display("FAIL reset_regs: key=%h num=%h rcon=%h expected zeros", round_key, round_num, dut.rcon_reg);
      end
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      asserts++;
      if (key_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_hold: valid=%b busy=%b expected 00", key_valid, busy);
      end
      $display("test_reset done");
   endtask

   task automatic test_a1_walk();
      exp_t e;
      sb.delete();
      push_a1();
      key_ready = 1'b1;
      do_start(a1_keys[10]);
      for (int c = 1; c <= 13; c++) begin
         if (c <= 11) begin
            asserts++;
            if (key_valid !== 1'b1 || busy !== 1'b1 || sb.size() == 0) begin
               fails++;
               $display("FAIL a1_valid c=%0d: valid=%b busy=%b expected 11", c, key_valid, busy);
            end else begin
               e = sb.pop_front();
               asserts++;
               if (round_num !== e.rn || round_key !== e.key) begin
                  fails++;
                  $display("FAIL a1_key c=%0d: got %h/%h expected %h/%h", c, round_num, round_key, e.rn, e.key);
               end
               if (e.rn != 4'h0) begin
                  asserts++;
                  if (dut.rcon_reg !== rcon_exp[e.rn]) begin
                     fails++;
                     $display("FAIL a1_rcon round %0d: got %h expected %h", e.rn, dut.rcon_reg, rcon_exp[e.rn]);
                  end
               end
            end
         end else begin
            asserts++;
            if (done !== (c == 12) || key_valid !== 1'b0 || busy !== 1'b0) begin
               fails++;
               $display("FAIL a1_done c=%0d: done=%b valid=%b busy=%b expected %b00", c, done, key_valid, busy, c == 12);
            end
         end
         @(negedge clk);
      end
      $display("test_a1_walk done");
   endtask

   task automatic test_backpressure();
      exp_t         e;
      logic [127:0] prev_key;
      logic [3:0]   prev_num;
      logic         stalled;
      int           cyc;
      sb.delete();
      push_a1();
      key_ready = 1'b0;
      do_start(a1_keys[10]);
      stalled = 1'b0;
      prev_key = '0;
      prev_num = '0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 300) begin
         asserts++;
         if (key_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_valid cyc=%0d: valid=%b expected 1", cyc, key_valid);
         end
         asserts++;
         if (round_num !== sb[0].rn || round_key !== sb[0].key) begin
            fails++;
            $display("FAIL bp_key cyc=%0d: got %h/%h expected %h/%h", cyc, round_num, round_key, sb[0].rn, sb[0].key);
         end
         if (stalled) begin
            asserts++;
            if (round_num !== prev_num || round_key !== prev_key) begin
               fails++;
               $display("FAIL bp_stable cyc=%0d: got %h/%h held %h/%h", cyc, round_num, round_key, prev_num, prev_key);
            end
         end
         prev_key = round_key;
         prev_num = round_num;
         key_ready = 1'($urandom_range(0, 1));
         stalled = ~key_ready;
         if (key_ready) e = sb.pop_front();
         cyc++;
         @(negedge clk);
      end
      asserts++;
      if (sb.size() != 0 || done !== 1'b1 || key_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_end: left=%0d done=%b valid=%b expected 0/1/0", sb.size(), done, key_valid);
      end
      key_ready = 1'b1;
      @(negedge clk);
      $display("test_backpressure done");
   endtask

   task automatic test_start_during_active();
      exp_t e;
      sb.delete();
      push_a1();
      key_ready = 1'b1;
      do_start(a1_keys[10]);
      for (int c = 1; c <= 11; c++) begin
         asserts++;
         if (key_valid !== 1'b1 || sb.size() == 0) begin
            fails++;
            $display("FAIL sda_valid c=%0d: valid=%b expected 1", c, key_valid);
         end else begin
            e = sb.pop_front();
            asserts++;
            if (round_num !== e.rn || round_key !== e.key) begin
               fails++;
               $display("FAIL sda_key c=%0d: got %h/%h expected %h/%h", c, round_num, round_key, e.rn, e.key);
            end
         end
         // Start at round 5 lands mid-walk; start at round 0 lands on the final handshake.
         start  = (round_num == 4'h5 || round_num == 4'h0);
         key_in = '1;
         @(negedge clk);
      end
      start = 1'b0;
      asserts++;
      if (done !== 1'b1 || key_valid !== 1'b0) begin
         fails++;
         $display("FAIL sda_done: done=%b valid=%b expected 10", done, key_valid);
      end
      @(negedge clk);
      asserts++;
      if (key_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL sda_no_restart: valid=%b busy=%b expected 00", key_valid, busy);
      end
      $display("test_start_during_active done");
   endtask

   task automatic test_reset_mid_walk();
      int cyc;
      key_ready = 1'b1;
      do_start(a1_keys[10]);
      cyc = 0;
      while (round_num !== 4'h6 && cyc < 20) begin
         cyc++;
         @(negedge clk);
      end
      asserts++;
      if (round_num !== 4'h6 || key_valid !== 1'b1) begin
         fails++;
         $display("FAIL rmw_reach: num=%h valid=%b expected 6/1", round_num, key_valid);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      asserts++;
      if (key_valid !== 1'b0 || busy !== 1'b0 || round_key !== 128'h0 || round_num !== 4'h0 || done !== 1'b0) begin
         fails++;
         $display("FAIL rmw_cleared: valid=%b busy=%b key=%h num=%h done=%b expected zeros",
                  key_valid, busy, round_key, round_num, done);
      end
      @(negedge clk);
      $display("test_reset_mid_walk done");
   endtask

   task automatic test_back_to_back();
      exp_t e;
      sb.delete();
      push_a1();
      key_ready = 1'b1;
      do_start(a1_keys[10]);
      for (int w = 0; w < 2; w++) begin
         for (int c = 1; c <= 11; c++) begin
            asserts++;
            if (key_valid !== 1'b1 || sb.size() == 0) begin
               fails++;
               $display("FAIL b2b_valid w=%0d c=%0d: valid=%b expected 1", w, c, key_valid);
            end else begin
               e = sb.pop_front();
               asserts++;
               if (round_num !== e.rn || (e.chk && round_key !== e.key)) begin
                  fails++;
                  $display("FAIL b2b_key w=%0d c=%0d: got %h/%h expected %h/%h", w, c, round_num, round_key, e.rn, e.key);
               end
            end
            @(negedge clk);
         end
         asserts++;
         if (done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done w=%0d: done=%b expected 1", w, done);
         end
         if (w == 0) begin
            push_zero();
            do_start(128'hb4ef5bcb3e92e21123e951cf6f8f188e);
         end
      end
      @(negedge clk);
      $display("test_back_to_back done");
   endtask

   initial begin
      a1_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      a1_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      a1_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      a1_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      a1_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      a1_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      a1_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      a1_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      a1_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      a1_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
      a1_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      rcon_exp[0]  = 8'h00;
      rcon_exp[1]  = 8'h01;
      rcon_exp[2]  = 8'h02;
      rcon_exp[3]  = 8'h04;
      rcon_exp[4]  = 8'h08;
      rcon_exp[5]  = 8'h10;
      rcon_exp[6]  = 8'h20;
      rcon_exp[7]  = 8'h40;
      rcon_exp[8]  = 8'h80;
      rcon_exp[9]  = 8'h1b;
      rcon_exp[10] = 8'h36;
      asserts = 0;
      fails = 0;
      clk = 1'b0;
      rst = 1'b1;
      start = 1'b0;
      key_in = '0;
      key_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_a1_walk();
      test_backpressure();
      test_start_during_active();
      test_reset_mid_walk();
      test_a1_walk();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Sequential inverse key-schedule engine for the AES-128 decryption path. It is loaded with the round-10 (final) round key and walks the key schedule backwards, one round key per accepted handshake, from round 10 down to round 0. It feeds the inverse-cipher datapath. It regenerates the round constant in reverse internally rather than indexing the forward round-constant lookup.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle load request; sampled only in IDLE.
- key_in  in  128  round-10 key, word0 = [127:96], word3 = [31:0], byte0 of each word is its MSB byte.
- key_ready  in  1  consumer accepts the presented round key this cycle.
- key_valid  out  1  round_key and round_num are valid.
- round_key  out  128  current round key, same word/byte order as key_in.
- round_num  out  4  round index of round_key: 4'ha down to 4'h0.
- busy  out  1  high in ACTIVE.
- done  out  1  one-cycle pulse after round 0 is accepted.

## Operation
- States: IDLE and ACTIVE.
- IDLE:
  - start=1 → register key_in into round_key, set round_num=4'ha and rcon_reg=8'h36, go to ACTIVE.
  - start=0 → stay in IDLE.
- ACTIVE:
  - key_valid=1 and busy=1.
  - A handshake occurs on any cycle with key_valid & key_ready.
  - Handshake with round_num≠0: replace round_key with the previous round key, decrement round_num, step rcon_reg backwards.
  - Handshake with round_num=0: go to IDLE and pulse done for one cycle.
- Previous round key, with current words w0..w3 and p = previous:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon_reg, 24'h0}
  - RotWord {a,b,c,d} → {b,c,d,a}.
  - SubWord applies the forward AES S-box to each byte: four combinational instances of the team's S-box block.
- rcon_reg at the current round_num r is Rcon(r): a→36, 9→1b, 8→80, 7→40, 6→20, 5→10, 4→08, 3→04, 2→02, 1→01.
- Reverse rcon step (GF(2^8) divide by x):
  - next = rcon_reg[0] ? (((rcon_reg ^ 8'h1b) >> 1) | 8'h80) : (rcon_reg >> 1)
  - rcon_reg is don't-care once round_num=0.
- Backpressure: when key_ready=0, round_key, round_num and rcon_reg hold stable, and key_valid stays high.
- start while ACTIVE is ignored; there is no restart mid-walk.
- start on the same cycle that round 0 is accepted is ignored; start is honoured from the following IDLE cycle.
- key_in is sampled only on the load cycle; later changes have no effect.

## Timing
- Reset values:
  - state=IDLE
  - key_valid=0, busy=0, done=0
  - round_key=128'h0, round_num=4'h0, rcon_reg=8'h00
- Load latency: start at cycle N → key_valid=1 with round 10 at N+1.
- Step latency: handshake at cycle N → next round key presented at N+1, one round per cycle at full rate.
- A full walk with key_ready held high is 11 valid cycles: N+1..N+11.
  - done=1 at N+12, with key_valid=0 and busy=0 that cycle.
  - New start is accepted at the earliest at N+12.
- round_key is fully registered; there is no combinational path from key_ready to any output.
- The S-box/XOR next-key logic completes in one cycle.
- rst=1 in any cycle, including mid-walk: next cycle is IDLE with all outputs at reset values; any partial walk is discarded.

## Test plan
- FIPS-197 A.1 walk:
  - Load key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 and hold key_ready=1.
  - Round 9 must be ac7766f319fadc2128d12941575c006e.
  - Round 0 must be 2b7e151628aed2a6abf7158809cf4f3c, with round_num 4'ha→4'h0 over 11 consecutive cycles.
  - done pulses once, 12 cycles after start.
- Backpressure: same key, random key_ready (≈50% duty).
  - The output sequence must equal the full-rate sequence.
  - round_key, round_num and key_valid must be stable on every cycle with key_ready=0.
- rcon coverage: check rcon_reg across the walk equals 36,1b,80,40,20,10,08,04,02,01; the 1b→80 step exercises the odd-LSB branch.
- start during ACTIVE:
  - Pulse start with key_in=all-ones at round 5.
  - The walk continues unchanged and ends at the A.1 round-0 key.
- Reset mid-walk:
  - Assert rst at round 6.
  - Next cycle: key_valid=0, busy=0, round_key=0, round_num=0.
  - A subsequent start performs a correct full walk.
- Back-to-back:
  - Start a second load, all-zero round-10 key b4ef5bcb3e92e21123e951cf6f8f188e, on the cycle done is high.
  - Round 0 must be 00000000000000000000000000000000.
